// File: rtl/pipe_ctl.sv
// Pipeline control for the 5-stage Beta core: operand bypass, load-use and
// data-memory stalls, branch redirect and interrupt injection.
module pipe_ctl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             dec_ra1,
  input  logic [4:0]             dec_ra2,
  input  logic                   dec_use1,
  input  logic                   dec_use2,
  input  logic                   dec_is_br,
  input  logic                   dec_br_taken,
  input  logic                   dec_pc_super,
  input  logic [4:0]             ex_rc,
  input  logic [4:0]             mem_rc,
  input  logic [4:0]             wb_rc,
  input  logic                   ex_wr,
  input  logic                   mem_wr,
  input  logic                   wb_wr,
  input  logic                   ex_ld,
  input  logic                   mem_ld,
  input  logic                   dmem_req,
  input  logic                   dmem_ack,
  input  logic                   irq,
  output logic [1:0]             byp_a,
  output logic [1:0]             byp_b,
  output logic                   stall_if,
  output logic                   stall_dec,
  output logic                   stall_all,
  output logic [1:0]             ir_src_dec,
  output logic [1:0]             ir_src_if,
  output logic [1:0]             pc_sel,
  output logic                   irq_ack,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_MWAIT = 2'd1,
    S_IRQ   = 2'd2
  } state_t;

  localparam logic [1:0] IR_DATA   = 2'b00;
  localparam logic [1:0] IR_NOP    = 2'b01;
  localparam logic [1:0] IR_EXCEPT = 2'b10;
  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BR     = 2'b01;
  localparam logic [1:0] PC_IRQ    = 2'b10;
  localparam logic [4:0] R31       = 5'd31;

  state_t state, state_nxt;
  logic   irq_pend;
  logic   irq_clr;
  logic   mem_stall;
  logic   load_use;

  // Youngest matching writer wins; R31 reads as zero so it never bypasses.
  function automatic logic [1:0] sel_src(
    input logic       use_r,
    input logic [4:0] ra,
    input logic       e_wr, input logic [4:0] e_rc,
    input logic       m_wr, input logic [4:0] m_rc,
    input logic       w_wr, input logic [4:0] w_rc
  );
    if (!use_r || ra == R31)     return 2'b00;
    else if (e_wr && e_rc == ra) return 2'b01;
    else if (m_wr && m_rc == ra) return 2'b10;
    else if (w_wr && w_rc == ra) return 2'b11;
    else                         return 2'b00;
  endfunction

  function automatic logic ld_hit(
    input logic       use_r,
    input logic [4:0] ra,
    input logic       e_ld, input logic [4:0] e_rc,
    input logic       m_ld, input logic [4:0] m_rc
  );
    return use_r && (ra != R31) &&
           ((e_ld && e_rc == ra) || (m_ld && m_rc == ra));
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_nxt  = state;
    irq_clr    = 1'b0;
    stall_if   = 1'b0;
    stall_dec  = 1'b0;
    stall_all  = 1'b0;
    ir_src_dec = IR_DATA;
    ir_src_if  = IR_DATA;
    pc_sel     = PC_INC;
    irq_ack    = 1'b0;
    byp_a      = sel_src(dec_use1, dec_ra1, ex_wr, ex_rc, mem_wr, mem_rc, wb_wr, wb_rc);
    byp_b      = sel_src(dec_use2, dec_ra2, ex_wr, ex_rc, mem_wr, mem_rc, wb_wr, wb_rc);
    mem_stall  = (state == S_MWAIT) || (dmem_req && !dmem_ack);
    load_use   = ld_hit(dec_use1, dec_ra1, ex_ld, ex_rc, mem_ld, mem_rc) ||
                 ld_hit(dec_use2, dec_ra2, ex_ld, ex_rc, mem_ld, mem_rc);

    if (mem_stall) begin
      // Whole pipe frozen; the ack cycle itself is still held.
      stall_if  = 1'b1;
      stall_dec = 1'b1;
      stall_all = 1'b1;
      state_nxt = (state == S_MWAIT && dmem_ack) ? S_RUN : S_MWAIT;
    end else if (state == S_IRQ) begin
      ir_src_dec = IR_EXCEPT;
      ir_src_if  = IR_NOP;
      pc_sel     = PC_IRQ;
      irq_ack    = 1'b1;
      irq_clr    = 1'b1;
      state_nxt  = S_RUN;
    end else if (load_use) begin
      stall_if   = 1'b1;
      stall_dec  = 1'b1;
      ir_src_dec = IR_NOP;
    end else if (irq_pend && !dec_pc_super && !dec_is_br) begin
      // Decode holds a sequential user instruction; it is replaced next cycle.
      state_nxt = S_IRQ;
    end else if (dec_is_br && dec_br_taken) begin
      pc_sel    = PC_BR;
      ir_src_if = IR_NOP;
    end

    if (rst) begin
      state_nxt  = S_RUN;
      irq_clr    = 1'b0;
      stall_if   = 1'b0;
      stall_dec  = 1'b0;
      stall_all  = 1'b0;
      ir_src_dec = IR_NOP;
      ir_src_if  = IR_NOP;
      pc_sel     = PC_INC;
      irq_ack    = 1'b0;
      byp_a      = 2'b00;
      byp_b      = 2'b00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_RUN;
      irq_pend  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state    <= state_nxt;
      irq_pend <= irq_clr ? 1'b0 : (irq_pend | irq);
      if (stall_if && stall_cnt != '1)
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctl.sv
// Directed bench for pipe_ctl: bypass, load-use, memory wait, branch, interrupt,
// reset and counter saturation (second instance with a 2-bit counter).
module tb_pipe_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] dec_ra1, dec_ra2, ex_rc, mem_rc, wb_rc;
  logic       dec_use1, dec_use2, dec_is_br, dec_br_taken, dec_pc_super;
  logic       ex_wr, mem_wr, wb_wr, ex_ld, mem_ld, dmem_req, dmem_ack, irq;

  logic [1:0]  byp_a, byp_b, ir_src_dec, ir_src_if, pc_sel;
  logic        stall_if, stall_dec, stall_all, irq_ack;
  logic [15:0] stall_cnt;

  logic [1:0]  s_byp_a, s_byp_b, s_ir_src_dec, s_ir_src_if, s_pc_sel;
  logic        s_stall_if, s_stall_dec, s_stall_all, s_irq_ack;
  logic [1:0]  s_stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_ctl u_dut (
    .clk(clk), .rst(rst),
    .dec_ra1(dec_ra1), .dec_ra2(dec_ra2), .dec_use1(dec_use1), .dec_use2(dec_use2),
    .dec_is_br(dec_is_br), .dec_br_taken(dec_br_taken), .dec_pc_super(dec_pc_super),
    .ex_rc(ex_rc), .mem_rc(mem_rc), .wb_rc(wb_rc),
    .ex_wr(ex_wr), .mem_wr(mem_wr), .wb_wr(wb_wr), .ex_ld(ex_ld), .mem_ld(mem_ld),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack), .irq(irq),
    .byp_a(byp_a), .byp_b(byp_b), .stall_if(stall_if), .stall_dec(stall_dec),
    .stall_all(stall_all), .ir_src_dec(ir_src_dec), .ir_src_if(ir_src_if),
    .pc_sel(pc_sel), .irq_ack(irq_ack), .stall_cnt(stall_cnt)
  );

  pipe_ctl #(.STALL_CNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .dec_ra1(dec_ra1), .dec_ra2(dec_ra2), .dec_use1(dec_use1), .dec_use2(dec_use2),
    .dec_is_br(dec_is_br), .dec_br_taken(dec_br_taken), .dec_pc_super(dec_pc_super),
    .ex_rc(ex_rc), .mem_rc(mem_rc), .wb_rc(wb_rc),
    .ex_wr(ex_wr), .mem_wr(mem_wr), .wb_wr(wb_wr), .ex_ld(ex_ld), .mem_ld(mem_ld),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack), .irq(irq),
    .byp_a(s_byp_a), .byp_b(s_byp_b), .stall_if(s_stall_if), .stall_dec(s_stall_dec),
    .stall_all(s_stall_all), .ir_src_dec(s_ir_src_dec), .ir_src_if(s_ir_src_if),
    .pc_sel(s_pc_sel), .irq_ack(s_irq_ack), .stall_cnt(s_stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    dec_ra1 = 5'd0; dec_ra2 = 5'd0; dec_use1 = 1'b0; dec_use2 = 1'b0;
    dec_is_br = 1'b0; dec_br_taken = 1'b0; dec_pc_super = 1'b0;
    ex_rc = 5'd0; mem_rc = 5'd0; wb_rc = 5'd0;
    ex_wr = 1'b0; mem_wr = 1'b0; wb_wr = 1'b0; ex_ld = 1'b0; mem_ld = 1'b0;
    dmem_req = 1'b0; dmem_ack = 1'b0; irq = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    #1;
    check("rst_ir_src_dec", ir_src_dec, 2'b01);
    check("rst_ir_src_if", ir_src_if, 2'b01);
    check("rst_stall_if", stall_if, 1'b0);
    check("rst_pc_sel", pc_sel, 2'b00);
    check("rst_stall_cnt", stall_cnt, 16'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;

    // Bypass: ADD writing R3 in ALU, decode reads R3
    ex_wr = 1'b1; ex_rc = 5'd3; dec_ra1 = 5'd3; dec_use1 = 1'b1; dec_ra2 = 5'd3;
    #1 check("byp_alu", byp_a, 2'b01);
    check("byp_unused", byp_b, 2'b00);
    mem_wr = 1'b1; mem_rc = 5'd3;
    #1 check("byp_alu_over_mem", byp_a, 2'b01);
    ex_wr = 1'b0;
    #1 check("byp_mem", byp_a, 2'b10);
    wb_wr = 1'b1; wb_rc = 5'd3; mem_wr = 1'b0;
    #1 check("byp_wb", byp_a, 2'b11);
    ex_wr = 1'b1; mem_wr = 1'b1; ex_rc = 5'd31; mem_rc = 5'd31; wb_rc = 5'd31;
    dec_ra1 = 5'd31; dec_ra2 = 5'd31; dec_use2 = 1'b1;
    #1 check("byp_r31_a", byp_a, 2'b00);
    check("byp_r31_b", byp_b, 2'b00);
    clear_inputs();
    tick();

    // Load-use with a taken branch in decode: redirect deferred until stall clears
    ex_rc = 5'd4; ex_wr = 1'b1; ex_ld = 1'b1;
    dec_ra2 = 5'd4; dec_use2 = 1'b1; dec_is_br = 1'b1; dec_br_taken = 1'b1;
    #2 check("lu1_stall_if", stall_if, 1'b1);
    check("lu1_stall_dec", stall_dec, 1'b1);
    check("lu1_stall_all", stall_all, 1'b0);
    check("lu1_ir_src_dec", ir_src_dec, 2'b01);
    check("lu1_pc_sel", pc_sel, 2'b00);
    tick();
    ex_wr = 1'b0; ex_ld = 1'b0; mem_rc = 5'd4; mem_wr = 1'b1; mem_ld = 1'b1;
    #2 check("lu2_stall_if", stall_if, 1'b1);
    check("lu2_ir_src_dec", ir_src_dec, 2'b01);
    check("lu2_pc_sel", pc_sel, 2'b00);
    tick();
    mem_wr = 1'b0; mem_ld = 1'b0; wb_rc = 5'd4; wb_wr = 1'b1;
    #2 check("lu3_stall_if", stall_if, 1'b0);
    check("lu3_byp_b", byp_b, 2'b11);
    check("lu3_ir_src_dec", ir_src_dec, 2'b00);
    check("br_pc_sel", pc_sel, 2'b01);
    check("br_ir_src_if", ir_src_if, 2'b01);
    check("lu_stall_cnt", stall_cnt, 16'd2);
    tick();
    clear_inputs();
    #2 check("br_done_pc_sel", pc_sel, 2'b00);
    check("br_done_ir_src_if", ir_src_if, 2'b00);
    check("sat_cnt_2", s_stall_cnt, 2'd2);

    // Memory wait: ack low for 3 cycles then high -> 4 stalled cycles
    dmem_req = 1'b1; dmem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2 check("mw_stall_all", stall_all, 1'b1);
      check("mw_stall_if", stall_if, 1'b1);
      check("mw_ir_src_dec", ir_src_dec, 2'b00);
      tick();
    end
    dmem_ack = 1'b1;
    #2 check("mw_ack_stall_all", stall_all, 1'b1);
    tick();
    dmem_req = 1'b0; dmem_ack = 1'b0;
    #2 check("mw_run_stall_all", stall_all, 1'b0);
    check("mw_run_stall_if", stall_if, 1'b0);
    check("mw_stall_cnt", stall_cnt, 16'd6);
    check("sat_cnt_3", s_stall_cnt, 2'd3);
    tick();
    dmem_req = 1'b1; dmem_ack = 1'b1;
    #2 check("mw_same_cycle_ack", stall_all, 1'b0);
    tick();
    clear_inputs();

    // Interrupt pulse from user mode
    irq = 1'b1;
    #2 check("irq_e_ack", irq_ack, 1'b0);
    tick();
    irq = 1'b0;
    #2 check("irq_f_ack", irq_ack, 1'b0);
    tick();
    #2 check("irq_g_ack", irq_ack, 1'b1);
    check("irq_g_pc_sel", pc_sel, 2'b10);
    check("irq_g_ir_src_dec", ir_src_dec, 2'b10);
    check("irq_g_ir_src_if", ir_src_if, 2'b01);
    tick();
    #2 check("irq_h_ack", irq_ack, 1'b0);
    check("irq_h_pc_sel", pc_sel, 2'b00);
    tick();
    #2 check("irq_once", irq_ack, 1'b0);

    // Interrupt held pending while decode is in supervisor mode
    dec_pc_super = 1'b1; irq = 1'b1;
    tick();
    irq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2 check("irq_super_hold", irq_ack, 1'b0);
      tick();
    end
    dec_pc_super = 1'b0;
    #2 check("irq_super_drop", irq_ack, 1'b0);
    tick();
    #2 check("irq_super_ack", irq_ack, 1'b1);
    check("irq_super_pc_sel", pc_sel, 2'b10);
    tick();
    #2 check("irq_super_done", irq_ack, 1'b0);
    clear_inputs();
    tick();

    // Reset during MWAIT
    dmem_req = 1'b1; ex_wr = 1'b1; ex_rc = 5'd3; dec_ra1 = 5'd3; dec_use1 = 1'b1;
    #2 check("rmw_stall_all", stall_all, 1'b1);
    tick();
    #2 check("rmw_in_mwait", stall_all, 1'b1);
    rst = 1'b1;
    #1 check("rmw_stall_all_forced", stall_all, 1'b0);
    check("rmw_stall_if_forced", stall_if, 1'b0);
    check("rmw_ir_src_dec", ir_src_dec, 2'b01);
    check("rmw_ir_src_if", ir_src_if, 2'b01);
    check("rmw_byp_a", byp_a, 2'b00);
    check("rmw_stall_cnt", stall_cnt, 16'd0);
    clear_inputs();
    @(posedge clk);
    #1 rst = 1'b0;
    #2 check("rmw_release_run", stall_all, 1'b0);
    check("rmw_release_cnt", stall_cnt, 16'd0);
    tick();
    #2 check("rmw_run_held", stall_all, 1'b0);
    check("rmw_ir_src_dec_data", ir_src_dec, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
